// File: rtl/pe_stream_feeder.sv
// Transmit-side feeder for the PE load/drain protocol: streams filter, ifmap and ipsum
// words from a shared memory port into the PE and writes opsum columns back.
module pe_stream_feeder #(
  parameter int DATA_BITS   = 32,
  parameter int ADDR_BITS   = 16,
  parameter int CONFIG_BITS = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CONFIG_BITS-1:0] cfg,
  input  logic [ADDR_BITS-1:0]   filter_base,
  input  logic [ADDR_BITS-1:0]   ifmap_base,
  input  logic [ADDR_BITS-1:0]   dw_base,
  input  logic [ADDR_BITS-1:0]   pw_base,
  input  logic [ADDR_BITS-1:0]   opsum_base,
  output logic                   busy,
  output logic                   done,
  output logic                   pe_en,
  output logic [CONFIG_BITS-1:0] pe_config,
  output logic                   mem_rd_en,
  output logic                   mem_wr_en,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [DATA_BITS-1:0]   mem_wdata,
  input  logic [DATA_BITS-1:0]   mem_rdata,
  output logic [DATA_BITS-1:0]   filter,
  output logic [DATA_BITS-1:0]   ifmap,
  output logic [DATA_BITS-1:0]   depthwise_ipsum,
  output logic [DATA_BITS-1:0]   pointwise_ipsum,
  output logic                   filter_valid,
  output logic                   ifmap_valid,
  output logic                   depthwise_ipsum_valid,
  output logic                   pointwise_ipsum_valid,
  input  logic                   filter_ready,
  input  logic                   ifmap_ready,
  input  logic                   depthwise_ipsum_ready,
  input  logic                   pointwise_ipsum_ready,
  input  logic [DATA_BITS-1:0]   opsum,
  input  logic                   opsum_valid,
  output logic                   opsum_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILTER, S_IFMAP, S_DWPS, S_PWPS, S_OPSUM, S_DONE
  } state_t;

  state_t                 r_state, w_next;
  logic [CONFIG_BITS-1:0] r_cfg;
  logic                   r_hold;   // 0: request phase, 1: word presented to the PE
  logic                   r_first;  // first HOLD cycle: read data is on mem_rdata
  logic                   r_pe_en;
  logic [DATA_BITS-1:0]   r_data;
  logic [4:0]             r_cnt;
  logic [5:0]             r_col;
  logic [ADDR_BITS-1:0]   r_ptr_filter, r_ptr_ifmap, r_ptr_dw, r_ptr_pw, r_ptr_opsum;

  logic       w_dw;
  logic [2:0] w_p, w_q, w_rs;
  logic [1:0] w_u;
  logic [4:0] w_f;
  logic       w_load, w_in_ready, w_xfer, w_op_xfer, w_rd;
  logic [4:0] w_target;
  logic       w_last_word, w_last_col;
  logic [DATA_BITS-1:0] w_word;

  assign w_dw = r_cfg[12];
  assign w_rs = {1'b0, r_cfg[11:10]} + 3'd1;
  assign w_u  = {1'b0, r_cfg[9]} + 2'd1;
  assign w_p  = {1'b0, r_cfg[8:7]} + 3'd1;
  assign w_f  = r_cfg[6:2];
  assign w_q  = {1'b0, r_cfg[1:0]} + 3'd1;

  assign w_load = (r_state == S_FILTER) || (r_state == S_IFMAP) ||
                  (r_state == S_DWPS)   || (r_state == S_PWPS);
  assign w_rd      = w_load && !r_hold;
  assign w_xfer    = w_load && r_hold && w_in_ready;
  assign w_op_xfer = (r_state == S_OPSUM) && opsum_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_in_ready = 1'b0;
    w_target   = 5'd0;
    case (r_state)
      S_FILTER: begin
        w_in_ready = filter_ready;
        w_target   = {2'b0, w_p} * {2'b0, w_rs};
      end
      S_IFMAP: begin
        w_in_ready = ifmap_ready;
        w_target   = (r_col == 6'd0) ? {2'b0, w_rs} : {3'b0, w_u};
      end
      S_DWPS: begin
        w_in_ready = depthwise_ipsum_ready;
        w_target   = w_dw ? {2'b0, w_q} : {2'b0, w_p};
      end
      S_PWPS: begin
        w_in_ready = pointwise_ipsum_ready;
        w_target   = {2'b0, w_p};
      end
      S_OPSUM: w_target = {2'b0, w_p};
      default: ;
    endcase
  end

  assign w_last_word = ((r_cnt + 5'd1) == w_target);
  assign w_last_col  = (r_col == {1'b0, w_f});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FILTER;
      S_FILTER: if (w_xfer && w_last_word) w_next = S_IFMAP;
      S_IFMAP:  if (w_xfer && w_last_word) w_next = S_DWPS;
      S_DWPS:   if (w_xfer && w_last_word) w_next = w_dw ? S_PWPS : S_OPSUM;
      S_PWPS:   if (w_xfer && w_last_word) w_next = S_OPSUM;
      S_OPSUM:  if (w_op_xfer && w_last_word) w_next = w_last_col ? S_DONE : S_IFMAP;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg        <= '0;
      r_hold       <= 1'b0;
      r_first      <= 1'b0;
      r_pe_en      <= 1'b0;
      r_data       <= '0;
      r_cnt        <= '0;
      r_col        <= '0;
      r_ptr_filter <= '0;
      r_ptr_ifmap  <= '0;
      r_ptr_dw     <= '0;
      r_ptr_pw     <= '0;
      r_ptr_opsum  <= '0;
    end else begin
      r_pe_en <= (r_state == S_IDLE) && start;
      r_first <= w_rd;
      if (r_first) r_data <= mem_rdata;

      if ((r_state == S_IDLE) && start) begin
        r_cfg        <= cfg;
        r_hold       <= 1'b0;
        r_cnt        <= '0;
        r_col        <= '0;
        r_ptr_filter <= filter_base;
        r_ptr_ifmap  <= ifmap_base;
        r_ptr_dw     <= dw_base;
        r_ptr_pw     <= pw_base;
        r_ptr_opsum  <= opsum_base;
      end

      if (w_rd) r_hold <= 1'b1;

      if (w_xfer) begin
        r_hold <= 1'b0;
        r_cnt  <= w_last_word ? 5'd0 : r_cnt + 5'd1;
        case (r_state)
          S_FILTER: r_ptr_filter <= r_ptr_filter + 1'b1;
          S_IFMAP:  r_ptr_ifmap  <= r_ptr_ifmap + 1'b1;
          S_DWPS:   r_ptr_dw     <= r_ptr_dw + 1'b1;
          S_PWPS:   r_ptr_pw     <= r_ptr_pw + 1'b1;
          default: ;
        endcase
      end

      if (w_op_xfer) begin
        r_ptr_opsum <= r_ptr_opsum + 1'b1;
        r_cnt       <= w_last_word ? 5'd0 : r_cnt + 5'd1;
        if (w_last_word) r_col <= r_col + 6'd1;
      end
    end
  end

  // The captured word is forwarded straight from mem_rdata on the first HOLD cycle.
  assign w_word = r_first ? mem_rdata : r_data;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pe_en     = r_pe_en;
  assign pe_config = r_cfg;

  assign filter_valid          = (r_state == S_FILTER) && r_hold;
  assign ifmap_valid           = (r_state == S_IFMAP)  && r_hold;
  assign depthwise_ipsum_valid = (r_state == S_DWPS)   && r_hold;
  assign pointwise_ipsum_valid = (r_state == S_PWPS)   && r_hold;

  assign filter          = filter_valid          ? w_word : '0;
  assign ifmap           = ifmap_valid           ? w_word : '0;
  assign depthwise_ipsum = depthwise_ipsum_valid ? w_word : '0;
  assign pointwise_ipsum = pointwise_ipsum_valid ? w_word : '0;

  assign opsum_ready = (r_state == S_OPSUM);
  assign mem_rd_en   = w_rd;
  assign mem_wr_en   = w_op_xfer;
  assign mem_wdata   = w_op_xfer ? opsum : '0;

  always_comb begin
    mem_addr = '0;
    if (w_rd) begin
      case (r_state)
        S_FILTER: mem_addr = r_ptr_filter;
        S_IFMAP:  mem_addr = r_ptr_ifmap;
        S_DWPS:   mem_addr = r_ptr_dw;
        S_PWPS:   mem_addr = r_ptr_pw;
        default:  mem_addr = '0;
      endcase
    end else if (w_op_xfer) begin
      mem_addr = r_ptr_opsum;
    end
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Self-checking bench for pe_stream_feeder: job table plus hand-written corner sequences,
// with per-stream scoreboards of expected words and an opsum write scoreboard.
module tb_pe_stream_feeder;

  logic        clk, rst_n, start;
  logic [12:0] cfg;
  logic [15:0] filter_base, ifmap_base, dw_base, pw_base, opsum_base;
  logic        busy, done, pe_en;
  logic [12:0] pe_config;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] filter, ifmap, depthwise_ipsum, pointwise_ipsum;
  logic        filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid;
  logic        filter_ready, ifmap_ready, depthwise_ipsum_ready, pointwise_ipsum_ready;
  logic [31:0] opsum;
  logic        opsum_valid, opsum_ready;

  pe_stream_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg(cfg),
    .filter_base(filter_base), .ifmap_base(ifmap_base), .dw_base(dw_base),
    .pw_base(pw_base), .opsum_base(opsum_base),
    .busy(busy), .done(done), .pe_en(pe_en), .pe_config(pe_config),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .filter(filter), .ifmap(ifmap), .depthwise_ipsum(depthwise_ipsum),
    .pointwise_ipsum(pointwise_ipsum),
    .filter_valid(filter_valid), .ifmap_valid(ifmap_valid),
    .depthwise_ipsum_valid(depthwise_ipsum_valid),
    .pointwise_ipsum_valid(pointwise_ipsum_valid),
    .filter_ready(filter_ready), .ifmap_ready(ifmap_ready),
    .depthwise_ipsum_ready(depthwise_ipsum_ready),
    .pointwise_ipsum_ready(pointwise_ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Memory model: read data appears the cycle after the request.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= pat(mem_addr);

  typedef struct {
    logic        dw;
    int          p, q, rs, u, f;
    logic [15:0] fb, ib, db, pb, ob;
    int          mode;  // 0 plain, 1 random handshakes, 2 filter backpressure, 3 start while busy
    int          nf, ni, nd, npw, nop;
  } job_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic fail_extra(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected word %0h expected none", name, act);
  endtask

  function automatic logic [12:0] mk_cfg(input job_t j);
    return {j.dw, 2'(j.rs - 1), 1'(j.u - 1), 2'(j.p - 1), 5'(j.f), 2'(j.q - 1)};
  endfunction

  function automatic job_t mk_job(input logic dw, input int p, q, rs, u, f, input logic [3:0] hi,
                                  input int mode, nf, ni, nd, npw, nop);
    job_t j;
    j.dw = dw; j.p = p; j.q = q; j.rs = rs; j.u = u; j.f = f;
    j.fb = {hi, 12'h000}; j.ib = {hi, 12'h100}; j.db = {hi, 12'h200};
    j.pb = {hi, 12'h300}; j.ob = {hi, 12'h400};
    j.mode = mode; j.nf = nf; j.ni = ni; j.nd = nd; j.npw = npw; j.nop = nop;
    return j;
  endfunction

  // Scoreboard and monitor state.
  logic [31:0] q_f[$], q_i[$], q_d[$], q_pw[$];
  logic [47:0] q_wr[$];
  string       tags, exp_tags;
  int          n_pe_en, n_done, viol, n_f, n_i, n_d, n_pw, n_o;
  logic [15:0] cur_ob;
  logic        cur_dw;
  bit          mon_en = 0;
  bit          rand_mode = 0;
  bit          bp_active = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pe_en) n_pe_en++;
      if (done) n_done++;
      if (mem_rd_en && mem_wr_en) viol++;
      if ($countones({filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid}) > 1) viol++;
      if (pointwise_ipsum_valid && !cur_dw) viol++;
      if (filter_valid && filter_ready) begin
        n_f++; tags = {tags, "F"};
        if (q_f.size() == 0) fail_extra("filter_extra", filter);
        else check("filter_data", filter, q_f.pop_front());
      end
      if (ifmap_valid && ifmap_ready) begin
        n_i++; tags = {tags, "I"};
        if (q_i.size() == 0) fail_extra("ifmap_extra", ifmap);
        else check("ifmap_data", ifmap, q_i.pop_front());
      end
      if (depthwise_ipsum_valid && depthwise_ipsum_ready) begin
        n_d++; tags = {tags, "D"};
        if (q_d.size() == 0) fail_extra("dw_extra", depthwise_ipsum);
        else check("dw_data", depthwise_ipsum, q_d.pop_front());
      end
      if (pointwise_ipsum_valid && pointwise_ipsum_ready) begin
        n_pw++; tags = {tags, "P"};
        if (q_pw.size() == 0) fail_extra("pw_extra", pointwise_ipsum);
        else check("pw_data", pointwise_ipsum, q_pw.pop_front());
      end
      if (opsum_valid && opsum_ready) begin
        tags = {tags, "O"};
        q_wr.push_back({16'(cur_ob + 16'(n_o)), opsum});
        n_o++;
        check("opsum_write", {15'd0, mem_wr_en, mem_addr, mem_wdata}, {15'd0, 1'b1, q_wr.pop_front()});
      end else if (mem_wr_en) begin
        viol++;
      end
    end
  end

  // Input driver: readies and opsum stream change just after each rising edge.
  int seq = 0;
  initial begin
    filter_ready = 0; ifmap_ready = 0; depthwise_ipsum_ready = 0;
    pointwise_ipsum_ready = 0; opsum_valid = 0; opsum = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        filter_ready          = 1'($urandom_range(0, 1));
        ifmap_ready           = 1'($urandom_range(0, 1));
        depthwise_ipsum_ready = 1'($urandom_range(0, 1));
        pointwise_ipsum_ready = 1'($urandom_range(0, 1));
        opsum_valid           = 1'($urandom_range(0, 1));
      end else begin
        filter_ready = 1; ifmap_ready = 1; depthwise_ipsum_ready = 1;
        pointwise_ipsum_ready = 1; opsum_valid = 1;
      end
      if (bp_active) filter_ready = 0;
      opsum = 32'hE000_0000 + 32'(seq);
      seq++;
    end
  end

  task automatic setup_job(input job_t j);
    int ip, dp, pp;
    cfg = mk_cfg(j);
    filter_base = j.fb; ifmap_base = j.ib; dw_base = j.db; pw_base = j.pb; opsum_base = j.ob;
    q_f.delete(); q_i.delete(); q_d.delete(); q_pw.delete(); q_wr.delete();
    tags = ""; exp_tags = "";
    n_pe_en = 0; n_done = 0; viol = 0; n_f = 0; n_i = 0; n_d = 0; n_pw = 0; n_o = 0;
    cur_ob = j.ob; cur_dw = j.dw;
    for (int i = 0; i < j.p * j.rs; i++) begin
      q_f.push_back(pat(16'(j.fb + 16'(i))));
      exp_tags = {exp_tags, "F"};
    end
    ip = 0; dp = 0; pp = 0;
    for (int c = 0; c <= j.f; c++) begin
      for (int k = 0; k < ((c == 0) ? j.rs : j.u); k++) begin
        q_i.push_back(pat(16'(j.ib + 16'(ip)))); ip++;
        exp_tags = {exp_tags, "I"};
      end
      for (int k = 0; k < (j.dw ? j.q : j.p); k++) begin
        q_d.push_back(pat(16'(j.db + 16'(dp)))); dp++;
        exp_tags = {exp_tags, "D"};
      end
      if (j.dw) begin
        for (int k = 0; k < j.p; k++) begin
          q_pw.push_back(pat(16'(j.pb + 16'(pp)))); pp++;
          exp_tags = {exp_tags, "P"};
        end
      end
      for (int k = 0; k < j.p; k++) exp_tags = {exp_tags, "O"};
    end
  endtask

  task automatic run_job(input job_t j);
    int c;
    setup_job(j);
    mon_en = 1;
    rand_mode = (j.mode == 1);
    bp_active = (j.mode == 2);
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    check("accept", {pe_en, busy, pe_config}, {1'b1, 1'b1, mk_cfg(j)});
    if (j.mode == 3) begin
      repeat (3) @(posedge clk);
      #1; cfg = ~mk_cfg(j); start = 1;
      repeat (2) @(posedge clk);
      #1; start = 0; cfg = mk_cfg(j);
      check("cfg_held_busy", {busy, pe_config}, {1'b1, mk_cfg(j)});
    end
    if (j.mode == 2) begin
      for (c = 0; c < 50 && !filter_valid; c++) @(negedge clk);
      check("bp_first_valid", filter_valid, 1'b1);
      repeat (10) begin
        @(negedge clk);
        check("bp_hold", {filter_valid, mem_rd_en, filter}, {1'b1, 1'b0, pat(j.fb)});
      end
      bp_active = 0;
    end
    for (c = 0; c < 20000 && !done; c++) @(negedge clk);
    check("done_seen", done, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("busy_after", busy, 1'b0);
    check("pe_en_pulses", 64'(n_pe_en), 64'd1);
    check("done_pulses", 64'(n_done), 64'd1);
    check("filter_count", 64'(n_f), 64'(j.nf));
    check("ifmap_count", 64'(n_i), 64'(j.ni));
    check("dw_count", 64'(n_d), 64'(j.nd));
    check("pw_count", 64'(n_pw), 64'(j.npw));
    check("opsum_count", 64'(n_o), 64'(j.nop));
    check_str("stream_order", tags, exp_tags);
    check("protocol_violations", 64'(viol), 64'd0);
    mon_en = 0; rand_mode = 0; bp_active = 0;
  endtask

  job_t jobs[6];
  job_t jx;

  initial begin
    int c;
    rst_n = 0; start = 0; cfg = '0;
    filter_base = '0; ifmap_base = '0; dw_base = '0; pw_base = '0; opsum_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, pe_en, mem_rd_en, mem_wr_en, opsum_ready,
                         filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid}, 0);
    check("reset_addr_cfg", {mem_addr, pe_config, mem_wdata}, 0);
    check("reset_streams", {filter, ifmap}, 0);
    @(negedge clk); rst_n = 1;

    //            dw  p  q  rs u  f   hi   mode nf  ni  nd  npw nop
    jobs[0] = mk_job(0, 2, 3, 3, 1, 1,  4'h0, 0,   6,  4,  4,  0,  4);
    jobs[1] = mk_job(1, 4, 2, 3, 2, 0,  4'h1, 0,  12,  3,  2,  4,  4);
    jobs[2] = mk_job(1, 1, 4, 2, 2, 2,  4'h2, 1,   2,  6, 12,  3,  3);
    jobs[3] = mk_job(0, 4, 1, 4, 1, 0,  4'h3, 1,  16,  4,  4,  0,  4);
    jobs[4] = mk_job(0, 1, 1, 1, 1, 31, 4'h4, 0,   1, 32, 32,  0, 32);
    jobs[5] = mk_job(0, 3, 2, 2, 2, 3,  4'h5, 1,   6,  8, 12,  0, 12);
    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Filter backpressure mid-word.
    jx = jobs[0]; jx.mode = 2; jx.fb = 16'h6000;
    run_job(jx);

    // start while busy is ignored and the in-flight depthwise job completes unchanged.
    jx = jobs[1]; jx.mode = 3;
    run_job(jx);

    // Reset in the middle of IFMAP aborts the job; a fresh start runs cleanly.
    setup_job(jobs[0]);
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    for (c = 0; c < 200 && !ifmap_valid; c++) @(negedge clk);
    check("reach_ifmap", ifmap_valid, 1'b1);
    rst_n = 0;
    #1;
    check("reset_async", {busy, done, pe_en, mem_rd_en, mem_wr_en, opsum_ready,
                          filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {busy, done, mem_rd_en}, 0);
    run_job(jobs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
- Transmit-side partner of the PE's valid/ready load/drain protocol.
- On start, latches a 13-bit PE config and pulses pe_en to the PE.
- Streams filter, ifmap, depthwise-ipsum and pointwise-ipsum words from a shared word-addressed memory port into the PE, in the order and quantity the PE consumes them.
- Collects opsum words and writes them back to memory, one column at a time, until F+1 output columns are done.

Parameters:
- DATA_BITS, 32, stream/memory word width.
- ADDR_BITS, 16, memory word-address width.
- CONFIG_BITS, 13, PE config width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a job; sampled only in IDLE
- cfg  in  CONFIG_BITS  [12] depthwise, [11:10] rs-1, [9] U-1, [8:7] p-1, [6:2] F, [1:0] q-1
- filter_base, ifmap_base, dw_base, pw_base, opsum_base  in  ADDR_BITS each  region start word addresses
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse after the last opsum write
- pe_en  out  1  one-cycle pulse on start accept
- pe_config  out  CONFIG_BITS  latched cfg, held stable while busy
- mem_rd_en  out  1  read request
- mem_wr_en  out  1  write strobe
- mem_addr  out  ADDR_BITS  read/write address
- mem_wdata  out  DATA_BITS  write data
- mem_rdata  in  DATA_BITS  read data, valid the cycle after mem_rd_en
- filter, ifmap, depthwise_ipsum, pointwise_ipsum  out  DATA_BITS each  PE input streams
- filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid  out  1 each
- filter_ready, ifmap_ready, depthwise_ipsum_ready, pointwise_ipsum_ready  in  1 each
- opsum  in  DATA_BITS
- opsum_valid  in  1
- opsum_ready  out  1

Behaviour:
- Reset: all outputs 0. State IDLE, all counters and address pointers 0.
- Reset mid-job aborts immediately; no done pulse is produced.
- Derived from latched cfg: p, q, rs in 1..4; U in 1..2; ncol = F+1.
- Per-job and per-column word counts:
  - filter words = p*rs, sent once per job.
  - ifmap words = rs for column 0; U for each later column.
  - Non-depthwise ipsum: p depthwise_ipsum words per column.
  - Depthwise ipsum: q depthwise_ipsum words, then p pointwise_ipsum words, per column.
  - opsum = p words per column.
  - U>rs is an unsupported config; behaviour is undefined.
- Address pointers: each region pointer is loaded from its base on start and increments by 1 per word transferred. Pointers never rewind across columns.
- FSM: IDLE -> FILTER -> IFMAP -> DWPS -> [PWPS if depthwise] -> OPSUM -> (IFMAP if col<ncol-1 else DONE) -> IDLE.
- IDLE: start=1 latches cfg and bases, pulses pe_en, sets busy, enters FILTER next cycle. start is ignored while busy.
- Load states (FILTER, IFMAP, DWPS, PWPS) each run two phases:
  - REQ: assert mem_rd_en=1 with mem_addr=pointer.
  - HOLD: capture mem_rdata into the stream register, hold that stream's valid=1 and the data stable until ready.
  - On valid&&ready: drop valid next cycle, pointer++, count++.
  - If count reaches its target, go to the next state; else return to REQ.
  - Minimum 2 cycles per word. Only one stream valid is ever high at a time.
- OPSUM: opsum_ready=1.
  - On opsum_valid&&opsum_ready (same cycle): mem_wr_en=1, mem_addr=opsum pointer, mem_wdata=opsum, then pointer++ and count++.
  - After p words: col++. If col==ncol go to DONE, else go to IFMAP.
- DONE: one cycle with done=1, busy=0 next cycle, back to IDLE.
- mem_rd_en and mem_wr_en are never high together.
- opsum_ready=0 outside OPSUM.
- Counters are 5-bit (max 16 words). The column counter is 6-bit, so F=31 gives 32 columns without wrap.

Test Plan:
- Non-depthwise, cfg p=2, q=3, rs=3, U=1, F=1: start -> pe_en single pulse.
  - Filter words: 6 from filter_base..+5.
  - Ifmap: 3 words, then 1 in column 1.
  - depthwise_ipsum: 2 per column.
  - opsum: 4 total written to opsum_base..+3.
  - done pulse exactly once.
- Depthwise, p=4, q=2, rs=3, U=2, F=0: per column 3 ifmap, 2 dw_ipsum, 4 pw_ipsum (pw_base..+3), 4 opsum writes; pointwise_ipsum_valid never high in non-depthwise mode.
- Backpressure: hold filter_ready=0 for 10 cycles mid-word -> filter_valid stays 1, data unchanged, pointer unchanged, no extra mem_rd_en.
- opsum_valid gaps: random opsum_valid toggling -> writes occur only on handshake cycles; addresses are consecutive with no duplicates.
- start asserted while busy -> ignored; no second pe_en; the in-flight job completes unchanged.
- rst_n low mid-IFMAP -> all valids, mem strobes and busy drop asynchronously; a new start afterwards runs a clean job from the bases.
